// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package rf_sched_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LSU
  } wb_src_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter.sv
// Grant logic for the single regfile write port: ALU over LSU, with an
// optional LSU starvation guard enabled by RF_WB_STARVE_GUARD_EN.
module rf_wb_arbiter
  import rf_sched_pkg::*;
`ifdef RF_WB_STARVE_GUARD_EN
#(
  parameter int MAX_WAIT = 4
)
`endif
(
`ifdef RF_WB_STARVE_GUARD_EN
  input  logic    clk,
  input  logic    clrn,
`endif
  input  logic    alu_valid,
  input  logic    lsu_valid,
  output logic    alu_ready,
  output logic    lsu_ready,
  output wb_src_e src
);

`ifdef RF_WB_STARVE_GUARD_EN
  logic [2:0] wait_cnt;
  logic       starve;

  // Once the LSU has waited MAX_WAIT cycles it takes the port from the ALU.
  assign starve    = (wait_cnt == 3'(MAX_WAIT)) & lsu_valid;
  assign alu_ready = alu_valid & ~starve;
  assign lsu_ready = lsu_valid & (~alu_valid | starve);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wait_cnt <= '0;
    end else if (lsu_ready) begin
      wait_cnt <= '0;
    end else if (lsu_valid && wait_cnt != 3'd7) begin
      wait_cnt <= wait_cnt + 3'd1;
    end
  end
`else
  assign alu_ready = alu_valid;
  assign lsu_ready = lsu_valid & ~alu_valid;
`endif

  always_comb begin
    src = WB_NONE;
    if (lsu_ready)      src = WB_LSU;
    else if (alu_ready) src = WB_ALU;
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Regfile write-port controller and busy-bit scoreboard with RAW/WAW issue stall.
// Optional LSU starvation guard: define RF_WB_STARVE_GUARD_EN.
module rf_wb_scheduler
#(
  parameter int XLEN = 32
`ifdef RF_WB_STARVE_GUARD_EN
  , parameter int MAX_WAIT = 4
`endif
)
(
  input  logic            clk,
  input  logic            clrn,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  output logic            issue_stall,
  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,
  input  logic            lsu_wb_valid,
  input  logic [4:0]      lsu_wb_rd,
  input  logic [XLEN-1:0] lsu_wb_data,
  output logic            lsu_wb_ready,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy_vec
);

  import rf_sched_pkg::*;

  wb_src_e             src;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [REG_AW-1:0]   sel_rd;
  logic [XLEN-1:0]     sel_data;
  logic                issue_fire;

  rf_wb_arbiter
`ifdef RF_WB_STARVE_GUARD_EN
    #(.MAX_WAIT(MAX_WAIT))
`endif
    u_arb (
`ifdef RF_WB_STARVE_GUARD_EN
    .clk      (clk),
    .clrn     (clrn),
`endif
    .alu_valid(alu_wb_valid),
    .lsu_valid(lsu_wb_valid),
    .alu_ready(alu_wb_ready),
    .lsu_ready(lsu_wb_ready),
    .src      (src)
  );

  assign issue_stall = issue_valid &
                       ((issue_use_rs1 & busy[issue_rs1]) |
                        (issue_use_rs2 & busy[issue_rs2]) |
                        busy[issue_rd]);
  assign issue_fire  = issue_valid & ~issue_stall;
  assign busy_vec    = busy;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    case (src)
      WB_ALU: begin
        sel_rd   = alu_wb_rd;
        sel_data = alu_wb_data;
      end
      WB_LSU: begin
        sel_rd   = lsu_wb_rd;
        sel_data = lsu_wb_data;
      end
      default: ;
    endcase
  end

  // Clear on the commit edge, then set from issue so that set wins; x0 never busy.
  always_comb begin
    busy_next = busy;
    if (rf_we)      busy_next[rf_waddr] = 1'b0;
    if (issue_fire) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      busy     <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      busy  <= busy_next;
      rf_we <= (src != WB_NONE) && (sel_rd != '0);
      if (src != WB_NONE) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed scenarios then randomized
// traffic, every cycle compared against a behavioural scoreboard model.
module tb_rf_wb_scheduler;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        clrn;
  logic        issue_valid, issue_use_rs1, issue_use_rs2, issue_stall;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        alu_wb_valid, alu_wb_ready, lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  alu_wb_rd, lsu_wb_rd, rf_waddr;
  logic [31:0] alu_wb_data, lsu_wb_data, rf_wdata, busy_vec;
  logic        rf_we;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.XLEN(32)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2),
    .issue_stall  (issue_stall),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .lsu_wb_ready (lsu_wb_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy_vec     (busy_vec)
  );

  int vector_count = 0;
  int miss_count   = 0;

  // Reference model: a set of pending registers plus the write committing next.
  bit          m_busy[32];
  bit          m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  bit          m_after_reset;
  int          m_wait;
  bit          last_alu_gnt, last_lsu_gnt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vector_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy_word();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = m_busy[i];
    return w;
  endfunction

  // Drive one cycle of inputs, check against the model, then advance the model.
  task automatic applyStimulus(input bit rstn,
                               input bit iv, input int ird, input int irs1, input int irs2,
                               input bit u1, input bit u2,
                               input bit av, input int ard, input logic [31:0] ad,
                               input bit lv, input int lrd, input logic [31:0] ld);
    bit e_stall, e_alu, e_lsu, starve, fire;
    clrn          = rstn;
    issue_valid   = iv;
    issue_rd      = 5'(ird);
    issue_rs1     = 5'(irs1);
    issue_rs2     = 5'(irs2);
    issue_use_rs1 = u1;
    issue_use_rs2 = u2;
    alu_wb_valid  = av;
    alu_wb_rd     = 5'(ard);
    alu_wb_data   = ad;
    lsu_wb_valid  = lv;
    lsu_wb_rd     = 5'(lrd);
    lsu_wb_data   = ld;

    e_stall = iv && ((u1 && m_busy[irs1]) || (u2 && m_busy[irs2]) || m_busy[ird]);
`ifdef RF_WB_STARVE_GUARD_EN
    starve = lv && (m_wait == MAX_WAIT);
`else
    starve = 1'b0;
`endif
    e_alu = av && !starve;
    e_lsu = lv && (!av || starve);
    fire  = iv && !e_stall;

    @(negedge clk);
    checkOutput("issue_stall", 32'(issue_stall), 32'(e_stall));
    checkOutput("alu_wb_ready", 32'(alu_wb_ready), 32'(e_alu));
    checkOutput("lsu_wb_ready", 32'(lsu_wb_ready), 32'(e_lsu));
    checkOutput("rf_we", 32'(rf_we), 32'(m_we));
    checkOutput("busy_vec", busy_vec, model_busy_word());
    if (m_we || m_after_reset) begin
      checkOutput("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      checkOutput("rf_wdata", rf_wdata, m_wdata);
    end

    if (!rstn) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_we = 1'b0; m_waddr = 0; m_wdata = '0; m_after_reset = 1'b1; m_wait = 0;
    end else begin
      if (m_we) m_busy[m_waddr] = 1'b0;
      if (fire && ird != 0) m_busy[ird] = 1'b1;
      if (e_alu || e_lsu) begin
        m_waddr       = e_alu ? ard : lrd;
        m_wdata       = e_alu ? ad : ld;
        m_we          = (m_waddr != 0);
        m_after_reset = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (e_lsu) m_wait = 0;
      else if (lv && m_wait < 7) m_wait++;
    end
    last_alu_gnt = e_alu;
    last_lsu_gnt = e_lsu;

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0,0,0,0,0,0, 0,0,0, 0,0,0);
  endtask

  bit          a_v, l_v;
  int          a_rd, l_rd;
  logic [31:0] a_d, l_d;

  initial begin
    clrn = 1'b0;
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_use_rs1 = 0; issue_use_rs2 = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
    m_we = 0; m_waddr = 0; m_wdata = '0; m_after_reset = 1; m_wait = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with every requester active.
    applyStimulus(0, 1,4,4,4,1,1, 1,3,32'h1111, 1,7,32'h2222);
    applyStimulus(0, 1,4,4,4,1,1, 1,3,32'h1111, 1,7,32'h2222);
    idle(2);

    // RAW on x5, ALU commit of 0xDEADBEEF releases the dependent issue.
    applyStimulus(1, 1,5,0,0,0,0, 0,0,0, 0,0,0);
    applyStimulus(1, 1,6,5,0,1,0, 1,5,32'hDEADBEEF, 0,0,0);
    applyStimulus(1, 1,6,5,0,1,0, 0,0,0, 0,0,0);
    applyStimulus(1, 1,6,5,0,1,0, 0,0,0, 0,0,0);
    idle(1);

    // Same-cycle ALU/LSU conflict.
    applyStimulus(1, 0,0,0,0,0,0, 1,3,32'hA3A3, 1,7,32'hB7B7);
    applyStimulus(1, 0,0,0,0,0,0, 0,0,0, 1,7,32'hB7B7);
    idle(2);

    // x0 never stalls and is never written.
    applyStimulus(1, 1,0,0,0,0,0, 0,0,0, 0,0,0);
    applyStimulus(1, 1,8,0,0,1,1, 0,0,0, 1,0,32'h5555);
    idle(2);

    // WAW on x9.
    applyStimulus(1, 1,9,0,0,0,0, 0,0,0, 0,0,0);
    applyStimulus(1, 1,9,0,0,0,0, 0,0,0, 0,0,0);
    applyStimulus(1, 1,9,0,0,0,0, 0,0,0, 1,9,32'h9999);
    applyStimulus(1, 1,9,0,0,0,0, 0,0,0, 0,0,0);
    applyStimulus(1, 1,9,0,0,0,0, 0,0,0, 0,0,0);
    applyStimulus(1, 1,12,9,0,1,0, 1,9,32'h0909, 0,0,0);
    idle(3);

    // ALU hogs the port while the LSU waits on x10.
    l_v = 1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0,0,0,0,0,0, 1,11,32'hC0DE0000 + 32'(i), l_v,10,32'h10101010);
      if (last_lsu_gnt) l_v = 0;
    end
    if (l_v) applyStimulus(1, 0,0,0,0,0,0, 0,0,0, 1,10,32'h10101010);
    idle(2);

    // Randomized traffic; ungranted requesters hold their request stable.
    a_v = 0; l_v = 0; a_rd = 0; l_rd = 0; a_d = '0; l_d = '0;
    for (int c = 0; c < 600; c++) begin
      int ird, irs1, irs2;
      bit rstn;
      rstn = (c != 300);
      if (!a_v || last_alu_gnt) begin
        a_v = ($urandom_range(0, 2) != 0); a_rd = $urandom_range(0, 7); a_d = $urandom;
      end
      if (!l_v || last_lsu_gnt) begin
        l_v = ($urandom_range(0, 1) != 0); l_rd = $urandom_range(0, 7); l_d = $urandom;
      end
      ird  = $urandom_range(0, 7);
      irs1 = $urandom_range(0, 7);
      irs2 = $urandom_range(0, 7);
      applyStimulus(rstn, ($urandom_range(0, 1) != 0), ird, irs1, irs2,
                    ($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0),
                    a_v, a_rd, a_d, l_v, l_rd, l_d);
      if (!rstn) begin
        a_v = 0; l_v = 0; last_alu_gnt = 0; last_lsu_gnt = 0;
      end
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
